// File: rtl/mips_pkg.sv
// Shared widths and MEM/WB pipeline types for the MIPS-lite datapath.
package mips_pkg;
    localparam int DW        = 16;                  // datapath width
    localparam int RW        = 4;                   // register address width
    localparam int MEM_DEPTH = 32;                  // data memory words
    localparam int MEM_AW    = $clog2(MEM_DEPTH);   // word index width
    localparam int CNT_W     = 8;                   // load/store counter width

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic          regwrite;
        logic          memtoreg;
        logic [RW-1:0] regw;
        logic [DW-1:0] ld_data;
        logic [DW-1:0] alu;
    } memwb_t;

    // Only even byte addresses that fall inside the array are legal.
    function automatic logic addr_ok(input logic [DW-1:0] a);
        return (a[DW-1:MEM_AW+1] == '0) && !a[0];
    endfunction
endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM inputs, hazard controls and WB-side outputs of the MEM stage.
interface mem_wb_stage_if;
    import mips_pkg::*;

    logic             branch_m, memread_m, memwrite_m, regwrite_m, memtoreg_m;
    logic             zero_m;
    logic [DW-1:0]    alu_result_m;
    logic [DW-1:0]    store_data_m;
    logic [RW-1:0]    regw_m;
    logic             stall, flush;
    logic             pcsrc;
    logic             regwrite_w;
    logic [RW-1:0]    regw_w;
    logic [DW-1:0]    writedata_w;
    logic             mem_err;
    logic [CNT_W-1:0] ld_count, st_count;

    // Upstream pipeline / hazard unit side
    modport master (
        output branch_m, memread_m, memwrite_m, regwrite_m, memtoreg_m, zero_m,
               alu_result_m, store_data_m, regw_m, stall, flush,
        input  pcsrc, regwrite_w, regw_w, writedata_w, mem_err, ld_count, st_count
    );

    // MEM stage side
    modport slave (
        input  branch_m, memread_m, memwrite_m, regwrite_m, memtoreg_m, zero_m,
               alu_result_m, store_data_m, regw_m, stall, flush,
        output pcsrc, regwrite_w, regw_w, writedata_w, mem_err, ld_count, st_count
    );
endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Data memory: synchronous write, asynchronous read, synchronous clear.
module data_mem
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata
);
    logic [DW-1:0] mem [MEM_DEPTH];

    // Clear wipes every word and wins over a coincident write.
    always_ff @(posedge clk) begin
        if (!clear) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: data memory access, writeback mux,
// load/store counters and sticky bad-address flag.
module mem_wb_stage
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic          clear,
    mem_wb_stage_if.slave bus
);
    logic          ok, take, is_ld, is_st, we;
    logic [DW-1:0] rd_raw, rd_data;
    memwb_t        r, nxt;

    assign ok    = addr_ok(bus.alu_result_m);
    assign take  = !bus.stall && !bus.flush;
    // Read+write together is a store only.
    assign is_st = bus.memwrite_m;
    assign is_ld = bus.memread_m && !bus.memwrite_m;
    assign we    = is_st && ok && take;

    data_mem u_mem (
        .clk   (clk),
        .clear (clear),
        .we    (we),
        .addr  (bus.alu_result_m[MEM_AW:1]),
        .wdata (bus.store_data_m),
        .rdata (rd_raw)
    );

    assign rd_data   = ok ? rd_raw : '0;
    assign bus.pcsrc = bus.branch_m & bus.zero_m;

    // Next MEM/WB contents; a faulting load must not write the register file.
    always_comb begin
        nxt          = '0;
        nxt.regwrite = bus.regwrite_m && !(is_ld && !ok);
        nxt.memtoreg = bus.memtoreg_m;
        nxt.regw     = bus.regw_m;
        nxt.ld_data  = rd_data;
        nxt.alu      = bus.alu_result_m;
    end

    // MEM/WB register: flush inserts a bubble, stall holds.
    always_ff @(posedge clk) begin
        if (!clear)         r <= '0;
        else if (bus.flush) r <= '0;
        else if (!bus.stall) r <= nxt;
    end

    // Sticky error and completed-access counters, updated only on accepted cycles.
    always_ff @(posedge clk) begin
        if (!clear) begin
            bus.mem_err  <= 1'b0;
            bus.ld_count <= '0;
            bus.st_count <= '0;
        end else if (take) begin
            if ((bus.memread_m || bus.memwrite_m) && !ok) bus.mem_err <= 1'b1;
            if (is_ld && ok) bus.ld_count <= bus.ld_count + 1'b1;
            if (is_st && ok) bus.st_count <= bus.st_count + 1'b1;
        end
    end

    assign bus.regwrite_w  = r.regwrite;
    assign bus.regw_w      = r.regw;
    assign bus.writedata_w = r.memtoreg ? r.ld_data : r.alu;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a queue-based scoreboard.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   failures = 0;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (.clk(clk), .clear(clear), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rw;
        logic [3:0]  rg;
        logic [15:0] wd;
        logic        err;
        logic [7:0]  ld;
        logic [7:0]  st;
        logic        pc;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input string fld, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", name, fld, act, req);
        end
    endtask

    // Monitor: one expected entry per checked cycle, compared just after the edge.
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "regwrite_w", {15'b0, bus.regwrite_w}, {15'b0, e.rw});
            chk(e.name, "regw_w", {12'b0, bus.regw_w}, {12'b0, e.rg});
            chk(e.name, "writedata_w", bus.writedata_w, e.wd);
            chk(e.name, "mem_err", {15'b0, bus.mem_err}, {15'b0, e.err});
            chk(e.name, "ld_count", {8'b0, bus.ld_count}, {8'b0, e.ld});
            chk(e.name, "st_count", {8'b0, bus.st_count}, {8'b0, e.st});
            chk(e.name, "pcsrc", {15'b0, bus.pcsrc}, {15'b0, e.pc});
        end
    end

    // Drive one MEM-cycle's worth of inputs.
    task automatic drv(input logic br, input logic zr, input logic rd, input logic wr,
                       input logic rwm, input logic mtr, input logic [15:0] alu,
                       input logic [15:0] sd, input logic [3:0] rg,
                       input logic stl, input logic fl);
        bus.branch_m = br;  bus.zero_m = zr;
        bus.memread_m = rd; bus.memwrite_m = wr;
        bus.regwrite_m = rwm; bus.memtoreg_m = mtr;
        bus.alu_result_m = alu; bus.store_data_m = sd; bus.regw_m = rg;
        bus.stall = stl; bus.flush = fl;
    endtask

    // Expected WB-side state after the coming edge.
    task automatic expect_nxt(input string name, input logic rw, input logic [3:0] rg,
                              input logic [15:0] wd, input logic err,
                              input logic [7:0] ld, input logic [7:0] st, input logic pc);
        exp_t e;
        e.name = name; e.rw = rw; e.rg = rg; e.wd = wd;
        e.err = err; e.ld = ld; e.st = st; e.pc = pc;
        q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        //    br zr rd wr rw mt alu       sd        rg  st fl
        clear = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0, 0, 0);
        expect_nxt("reset", 0, 0, 16'h0000, 0, 8'd0, 8'd0, 0); tick();
        tick();
        clear = 1'b1;

        // Store then load the same word
        drv(0, 0, 0, 1, 0, 0, 16'h000A, 16'hBEEF, 4'd0, 0, 0);
        expect_nxt("store_beef", 0, 0, 16'h000A, 0, 8'd0, 8'd1, 0); tick();
        drv(0, 0, 1, 0, 1, 1, 16'h000A, 16'h0000, 4'd3, 0, 0);
        expect_nxt("load_beef", 1, 3, 16'hBEEF, 0, 8'd1, 8'd1, 0); tick();

        // R-type passthrough
        drv(0, 0, 0, 0, 1, 0, 16'h1234, 16'h0000, 4'd5, 0, 0);
        expect_nxt("rtype", 1, 5, 16'h1234, 0, 8'd1, 8'd1, 0); tick();

        // Branch select
        drv(1, 1, 0, 0, 1, 0, 16'h0002, 16'h0000, 4'd6, 0, 0);
        expect_nxt("branch_taken", 1, 6, 16'h0002, 0, 8'd1, 8'd1, 1); tick();
        drv(1, 0, 0, 0, 0, 0, 16'h0004, 16'h0000, 4'd0, 0, 0);
        expect_nxt("branch_not", 0, 0, 16'h0004, 0, 8'd1, 8'd1, 0); tick();

        // Misaligned load: sticky error, no regwrite, no count
        drv(0, 0, 1, 0, 1, 1, 16'h0041, 16'h0000, 4'd7, 0, 0);
        expect_nxt("load_odd", 0, 7, 16'h0000, 1, 8'd1, 8'd1, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0, 0, 0);
        expect_nxt("err_sticky", 0, 0, 16'h0000, 1, 8'd1, 8'd1, 0); tick();
        // Out-of-range store also flags, no count
        drv(0, 0, 0, 1, 0, 0, 16'h0040, 16'h1111, 4'd0, 0, 0);
        expect_nxt("store_oor", 0, 0, 16'h0040, 1, 8'd1, 8'd1, 0); tick();

        // Stall holds WB and suppresses the write
        drv(0, 0, 0, 0, 1, 0, 16'h00AA, 16'h0000, 4'd2, 0, 0);
        expect_nxt("pre_stall", 1, 2, 16'h00AA, 1, 8'd1, 8'd1, 0); tick();
        drv(0, 0, 0, 1, 0, 0, 16'h000C, 16'h5555, 4'd0, 1, 0);
        expect_nxt("stall_hold", 1, 2, 16'h00AA, 1, 8'd1, 8'd1, 0); tick();
        drv(0, 0, 1, 0, 1, 1, 16'h000C, 16'h0000, 4'd4, 0, 0);
        expect_nxt("stall_nowrite", 1, 4, 16'h0000, 1, 8'd2, 8'd1, 0); tick();
        drv(0, 0, 0, 1, 0, 0, 16'h000C, 16'h5555, 4'd0, 0, 0);
        expect_nxt("store_5555", 0, 0, 16'h000C, 1, 8'd2, 8'd2, 0); tick();
        drv(0, 0, 1, 0, 1, 1, 16'h000C, 16'h0000, 4'd4, 0, 0);
        expect_nxt("load_5555", 1, 4, 16'h5555, 1, 8'd3, 8'd2, 0); tick();

        // Stall+flush: bubble, no write, no count
        drv(0, 0, 0, 1, 1, 0, 16'h000C, 16'h1111, 4'd9, 1, 1);
        expect_nxt("stall_flush", 0, 0, 16'h0000, 1, 8'd3, 8'd2, 0); tick();
        drv(0, 0, 1, 0, 1, 1, 16'h000C, 16'h0000, 4'd4, 0, 0);
        expect_nxt("flush_nowrite", 1, 4, 16'h5555, 1, 8'd4, 8'd2, 0); tick();

        // Read+write together counts as a store only
        drv(0, 0, 1, 1, 1, 0, 16'h0010, 16'h7777, 4'd8, 0, 0);
        expect_nxt("rd_wr_both", 1, 8, 16'h0010, 1, 8'd4, 8'd3, 0); tick();
        drv(0, 0, 1, 0, 1, 1, 16'h0010, 16'h0000, 4'd8, 0, 0);
        expect_nxt("load_7777", 1, 8, 16'h7777, 1, 8'd5, 8'd3, 0); tick();

        // Reset clears error and counters
        clear = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0, 0, 0);
        expect_nxt("reset2", 0, 0, 16'h0000, 0, 8'd0, 8'd0, 0); tick();
        clear = 1'b1;

        // Store counter wrap
        for (int i = 1; i <= 256; i++) begin
            drv(0, 0, 0, 1, 0, 0, 16'h0002, i[15:0], 4'd0, 0, 0);
            if (i == 255) expect_nxt("st_ff", 0, 0, 16'h0002, 0, 8'd0, 8'hFF, 0);
            if (i == 256) expect_nxt("st_wrap", 0, 0, 16'h0002, 0, 8'd0, 8'h00, 0);
            tick();
        end

        // Reset during a store: write dropped, everything at reset values
        clear = 1'b0;
        drv(0, 0, 0, 1, 1, 0, 16'h0004, 16'hABCD, 4'd1, 1, 1);
        expect_nxt("reset_mid_store", 0, 0, 16'h0000, 0, 8'd0, 8'd0, 0); tick();
        clear = 1'b1;
        drv(0, 0, 1, 0, 1, 1, 16'h0004, 16'h0000, 4'd1, 0, 0);
        expect_nxt("mem_clr_a4", 1, 1, 16'h0000, 0, 8'd1, 8'd0, 0); tick();
        drv(0, 0, 1, 0, 1, 1, 16'h0002, 16'h0000, 4'd2, 0, 0);
        expect_nxt("mem_clr_a2", 1, 2, 16'h0000, 0, 8'd2, 8'd0, 0); tick();

        drv(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0, 0, 0);
        tick();
        tick();
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
